new_pc_unit: RTL and testbench

Next-program-counter generator for the sequential RV64 datapath. Each falling clock edge it registers either the sequential successor (PC + 4) or the conditional-branch target (PC + imm·2). It sits between the fetch PC register and the branch/ALU decision logic. Branch is taken only when the control unit asserts Branch and the ALU reports Zero.

---
 rtl/new_pc_pkg.sv | 8 +
 rtl/pc_target_adder.sv | 15 +
 rtl/new_pc_unit.sv | 59 +++++
 tb/tb_new_pc_unit.sv | 109 ++++++++++
 4 files changed

// File: rtl/new_pc_pkg.sv
// Shared constants and types for the next-PC generator.
package new_pc_pkg;
    localparam int XLEN     = 64;
    localparam int PC_INCR  = 4;
    localparam int BR_SHIFT = 1;

    typedef logic [XLEN-1:0] addr_t;
endpackage

// File: rtl/pc_target_adder.sv
// Combinational adders for the sequential successor and the branch target.
module pc_target_adder
    import new_pc_pkg::*;
#(
    parameter int XLEN = new_pc_pkg::XLEN
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] seq_pc,
    output logic [XLEN-1:0] br_pc
);
    // imm is in halfword units; the shift drops its MSB and the sum wraps mod 2^XLEN.
    assign seq_pc = pc + XLEN'(PC_INCR);
    assign br_pc  = pc + (imm << BR_SHIFT);
endmodule

// File: rtl/new_pc_unit.sv
// Next-PC select and falling-edge register.
// Optional NEW_PC_ALIGN_CHECK_EN adds a registered 'misaligned' flag.
module new_pc_unit
    import new_pc_pkg::*;
#(
    parameter int XLEN = new_pc_pkg::XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            Branch,
    input  logic            Zero,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] PC,
`ifdef NEW_PC_ALIGN_CHECK_EN
    output logic            misaligned,
`endif
    output logic [XLEN-1:0] new_PC
);
    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] br_pc;
    logic [XLEN-1:0] new_pc_d;
    logic [XLEN-1:0] new_pc_q;

    pc_target_adder #(.XLEN(XLEN)) u_adder (
        .pc     (PC),
        .imm    (imm),
        .seq_pc (seq_pc),
        .br_pc  (br_pc)
    );

    always_comb begin
        new_pc_d = seq_pc;
        if (Branch && Zero) new_pc_d = br_pc;
    end

    // The whole datapath samples on the falling edge; reset is synchronous to it.
    always_ff @(negedge clk) begin
        if (reset) new_pc_q <= '0;
        else       new_pc_q <= new_pc_d;
    end

    assign new_PC = new_pc_q;

`ifdef NEW_PC_ALIGN_CHECK_EN
    logic misaligned_d;
    logic misaligned_q;

    always_comb begin
        misaligned_d = |new_pc_d[1:0];
    end

    always_ff @(negedge clk) begin
        if (reset) misaligned_q <= 1'b0;
        else       misaligned_q <= misaligned_d;
    end

    assign misaligned = misaligned_q;
`endif
endmodule

// File: tb/tb_new_pc_unit.sv
// Self-checking bench for new_pc_unit: directed cases then randomized traffic.
module tb_new_pc_unit;
    import new_pc_pkg::*;

    logic        clk;
    logic        reset;
    logic        Branch;
    logic        Zero;
    logic [63:0] imm;
    logic [63:0] PC;
    logic [63:0] new_PC;
`ifdef NEW_PC_ALIGN_CHECK_EN
    logic        misaligned;
`endif

    int n_checks = 0;
    int n_errors = 0;

    addr_t exp_pc;
    logic  exp_mis;

    new_pc_unit dut (
        .clk    (clk),
        .reset  (reset),
        .Branch (Branch),
        .Zero   (Zero),
        .imm    (imm),
        .PC     (PC),
`ifdef NEW_PC_ALIGN_CHECK_EN
        .misaligned (misaligned),
`endif
        .new_PC (new_PC)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    // Reference: next PC from the architectural rule, in plain 64-bit arithmetic.
    function automatic addr_t ref_next(input logic r, input logic b, input logic z,
                                       input addr_t pc, input addr_t im);
        addr_t res;
        if (r)           res = '0;
        else if (b && z) res = pc + im * 2;
        else             res = pc + 4;
        return res;
    endfunction

    // Drive inputs mid-cycle, cross one falling edge, then compare.
    task automatic step(input string tag, input logic r, input logic b, input logic z,
                        input addr_t pc, input addr_t im);
        reset = r; Branch = b; Zero = z; PC = pc; imm = im;
        exp_pc  = ref_next(r, b, z, pc, im);
        exp_mis = (exp_pc % 4) != 0;
        @(negedge clk);
        #1;
        chk(tag, new_PC, exp_pc);
`ifdef NEW_PC_ALIGN_CHECK_EN
        chk({tag, "_mis"}, {63'd0, misaligned}, {63'd0, exp_mis});
`endif
    endtask

    initial begin
        reset = 1'b1; Branch = 1'b0; Zero = 1'b0; PC = '0; imm = '0;
        @(negedge clk);
        #1;
        step("reset_init", 1'b1, 1'b0, 1'b0, 64'd12, 64'd0);

        step("seq",        1'b0, 1'b0, 1'b0, 64'd0,  64'd0);
        step("br_not_tkn", 1'b0, 1'b1, 1'b0, 64'd4,  64'd8);
        step("zero_only",  1'b0, 1'b0, 1'b1, 64'd20, 64'd8);
        step("br_pos",     1'b0, 1'b1, 1'b1, 64'd8,  64'd16);
        step("br_neg4",    1'b0, 1'b1, 1'b1, 64'd40, -64'sd4);
        step("br_neg10",   1'b0, 1'b1, 1'b1, 64'd50, -64'sd10);
        step("wrap_seq",   1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0);
        step("imm_msb",    1'b0, 1'b1, 1'b1, 64'd100, 64'h8000_0000_0000_0003);
        step("reset_ovr",  1'b1, 1'b1, 1'b1, 64'd100, 64'd5);
        step("post_reset", 1'b0, 1'b1, 1'b1, 64'd100, 64'd5);

        // Inputs wiggled between edges must not disturb the registered value.
        PC = 64'd7000; Branch = 1'b1; Zero = 1'b1; imm = 64'd3;
        #2;
        chk("hold_between_edges", new_PC, 64'd110);
        step("after_hold", 1'b0, 1'b1, 1'b1, 64'd7000, 64'd3);

        for (int i = 0; i < 300; i++) begin
            logic  r, b, z;
            addr_t pc, im;
            r  = ($urandom_range(0, 15) == 0);
            b  = $urandom_range(0, 1);
            z  = $urandom_range(0, 1);
            pc = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) pc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
            im = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) im = 64'($signed(32'($urandom_range(0, 4095)) - 32'sd2048));
            step("rand", r, b, z, pc, im);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
